card_dealer: RTL
================

Name: card_dealer

Overview:
Pseudo-random card source for the BlackJack datapath; sits directly downstream of the 2 kHz free-running counter.
- The counter value is captured as the seed for a 12-bit LFSR.
- On each draw request, draws one card from a tracked 52-card deck (4 copies per rank) and rejects exhausted ranks.
- Returns rank and blackjack value to the game controller with a one-cycle valid pulse.

Parameters:
SEED_W, 12, width of i_Seed; lower min(SEED_W,12) bits used, zero-padded to 12.
LFSR_INIT, 12'hACE, LFSR value after reset and substitute for an all-zero seed.

Ports:
clk_2K  input  1  2 kHz system clock.
i_ResetNeg  input  1  reset, asynchronous, active-high.
i_Seed  input  SEED_W  entropy source, driven by the counter's count output.
i_SeedLoad  input  1  load LFSR from i_Seed this edge.
i_DrawReq  input  1  request one card; sampled in IDLE only.
i_NewDeck  input  1  refill deck to 52 cards.
o_Card  output  4  rank 1..13 (1=Ace, 11..13=J,Q,K); 0 after reset.
o_CardValue  output  4  1 for Ace, rank for 2..10, 10 for J/Q/K.
o_CardValid  output  1  one-cycle pulse; o_Card/o_CardValue are valid while high.
o_Busy  output  1  high in EVAL and DONE.
o_CardsLeft  output  6  cards remaining, 0..52.
o_DeckEmpty  output  1  o_CardsLeft == 0.

Behaviour:
- Reset (async): state IDLE; LFSR=LFSR_INIT; all 13 rank counts=4; o_CardsLeft=52; o_Card=0, o_CardValue=0, o_CardValid=0, o_Busy=0, o_DeckEmpty=0.
- LFSR: Fibonacci, shift left. fb = l[11]^l[5]^l[3]^l[0]; next = {l[10:0], fb}. Never reaches 0.
- Seed load:
  - On i_SeedLoad, l <= (seed12 == 0) ? LFSR_INIT : seed12.
  - Allowed in any state.
  - Takes priority over an LFSR advance in the same edge.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - i_NewDeck: counts=4, o_CardsLeft=52; i_DrawReq ignored that edge.
  - else i_DrawReq && !o_DeckEmpty: advance LFSR (unless seed load), go to EVAL.
  - i_DrawReq while empty: ignored; no valid pulse; stay IDLE.
- EVAL (one candidate per edge):
  - cand = l[3:0].
  - Accept if cand in 1..13 and count[cand] > 0: latch o_Card/o_CardValue, decrement count[cand] and o_CardsLeft, go to DONE.
  - Else advance LFSR and stay in EVAL. Retry count is unbounded but always terminates, because the LFSR cycle covers every low nibble.
- DONE: o_CardValid=1 for exactly this cycle; go to IDLE.
- Latency:
  - Request sampled at edge E0; accept at E1 at the earliest; o_CardValid high between E1 and E2.
  - Each rejection adds one cycle.
- i_NewDeck in EVAL or DONE: abort; refill deck; go to IDLE.
  - A draw aborted in EVAL produces no valid pulse and no decrement.
  - In DONE, the card already dealt is discarded by the refill.
- o_Card/o_CardValue hold their last value until the next accept.
- Reset mid-draw: immediate return to the reset state; no pulse.
- o_DeckEmpty and o_CardsLeft are combinational from the counter register.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, EVAL=2'd1, DONE=2'd2);
  - DECK_COPIES=4, DECK_SIZE=52, NUM_RANKS=13;
  - LFSR_W=12 and the tap positions;
  - rank constants ACE=1, JACK=11, QUEEN=12, KING=13;
  - face value 10.
- One sub-module, card_lfsr: 12-bit register with load/advance enables, load priority and zero-seed substitution.
- Rank counts and the FSM stay in card_dealer.

Test Plan:
- Reset -> o_CardsLeft=52, o_DeckEmpty=0, o_CardValid=0, o_Card=0, o_Busy=0.
- Seed 12'h001, draw -> LFSR 0x003; o_Card=3, o_CardValue=3; valid 2 edges after request; o_CardsLeft=51.
- Seed 12'h007, draw -> candidates 0x00F (15) and 0x01E (14) rejected, 0x03D accepted; o_Card=13, o_CardValue=10; valid 4 edges after request.
- Reseed 12'h001 and draw 4 times -> rank 3 four times. Fifth reseed+draw: 0x003 rejected (rank exhausted), 0x007 accepted; o_Card=7.
- Seed 0 then draw -> LFSR loaded with 12'hACE, not stuck at 0. 52 draws -> o_DeckEmpty=1; 53rd i_DrawReq gives no pulse and o_Busy stays 0.
- i_NewDeck asserted in EVAL -> no valid pulse; o_CardsLeft=52, state IDLE. i_NewDeck + i_DrawReq in IDLE -> refill only, no draw.

Source files
------------

// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the BlackJack card dealer: FSM encoding,
// deck geometry, LFSR taps and rank/value constants.
package card_dealer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DECK_COPIES = 4;
  localparam int DECK_SIZE   = 52;
  localparam int NUM_RANKS   = 13;

  localparam int LFSR_W = 12;
  localparam int TAP_A  = 11;
  localparam int TAP_B  = 5;
  localparam int TAP_C  = 3;
  localparam int TAP_D  = 0;

  localparam logic [3:0] ACE        = 4'd1;
  localparam logic [3:0] JACK       = 4'd11;
  localparam logic [3:0] QUEEN      = 4'd12;
  localparam logic [3:0] KING       = 4'd13;
  localparam logic [3:0] FACE_VALUE = 4'd10;

  // Blackjack value of a rank: Ace counts 1 here, court cards count 10.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= JACK) ? FACE_VALUE : rank;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 12-bit Fibonacci LFSR with seed load (priority) and advance enables.
// An all-zero seed is replaced by LFSR_INIT so the register never locks up.
module card_lfsr
  import card_dealer_pkg::*;
#(
  parameter int                SEED_W    = 12,
  parameter logic [LFSR_W-1:0] LFSR_INIT = 12'hACE
) (
  input  logic              clk_2K,
  input  logic              i_ResetNeg,
  input  logic [SEED_W-1:0] seed,
  input  logic              load,
  input  logic              advance,
  output logic [3:0]        low_nibble
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] seed12;
  logic              feedback;

  if (SEED_W >= LFSR_W) begin : g_seed_trim
    assign seed12 = seed[LFSR_W-1:0];
  end else begin : g_seed_pad
    assign seed12 = {{(LFSR_W-SEED_W){1'b0}}, seed};
  end

  assign feedback   = lfsr[TAP_A] ^ lfsr[TAP_B] ^ lfsr[TAP_C] ^ lfsr[TAP_D];
  assign low_nibble = lfsr[3:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
    if (i_ResetNeg) begin
      lfsr <= LFSR_INIT;
    end else if (load) begin
      lfsr <= (seed12 == '0) ? LFSR_INIT : seed12;
    end else if (advance) begin
      lfsr <= {lfsr[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Pseudo-random card source: draws from a tracked 52-card deck using an
// LFSR candidate per cycle, rejecting out-of-range or exhausted ranks.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int                SEED_W    = 12,
  parameter logic [LFSR_W-1:0] LFSR_INIT = 12'hACE
) (
  input  logic              clk_2K,
  input  logic              i_ResetNeg,
  input  logic [SEED_W-1:0] i_Seed,
  input  logic              i_SeedLoad,
  input  logic              i_DrawReq,
  input  logic              i_NewDeck,
  output logic [3:0]        o_Card,
  output logic [3:0]        o_CardValue,
  output logic              o_CardValid,
  output logic              o_Busy,
  output logic [5:0]        o_CardsLeft,
  output logic              o_DeckEmpty
);

  state_t     state, next_state;
  logic [3:0] cand;
  logic       cand_ok;
  logic       advance;
  logic       refill;
  logic       accept;
  logic [2:0] counts [NUM_RANKS];

  card_lfsr #(
    .SEED_W   (SEED_W),
    .LFSR_INIT(LFSR_INIT)
  ) u_lfsr (
    .clk_2K    (clk_2K),
    .i_ResetNeg(i_ResetNeg),
    .seed      (i_Seed),
    .load      (i_SeedLoad),
    .advance   (advance),
    .low_nibble(cand)
  );

  assign o_DeckEmpty = (o_CardsLeft == 6'd0);
  assign o_CardValid = (state == DONE);
  assign o_Busy      = (state == EVAL) || (state == DONE);

  // Candidate is usable only for ranks 1..13 that still have copies left.
  always_comb begin
    cand_ok = 1'b0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (cand == 4'(r + 1) && counts[r] != 3'd0) cand_ok = 1'b1;
    end
  end

  always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
    if (i_ResetNeg) state <= IDLE;
    else            state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    refill     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (i_NewDeck) begin
          refill = 1'b1;
        end else if (i_DrawReq && !o_DeckEmpty) begin
          advance    = 1'b1;
          next_state = EVAL;
        end
      end
      EVAL: begin
        if (i_NewDeck) begin
          refill     = 1'b1;
          next_state = IDLE;
        end else if (cand_ok) begin
          accept     = 1'b1;
          next_state = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        refill     = i_NewDeck;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the rank counts are only 13 small registers, so they take the
  // async reset like any other flop rather than being treated as a RAM.
  always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
    if (i_ResetNeg) begin
      for (int r = 0; r < NUM_RANKS; r++) counts[r] <= 3'(DECK_COPIES);
      o_CardsLeft <= 6'(DECK_SIZE);
    end else if (refill) begin
      for (int r = 0; r < NUM_RANKS; r++) counts[r] <= 3'(DECK_COPIES);
      o_CardsLeft <= 6'(DECK_SIZE);
    end else if (accept) begin
      for (int r = 0; r < NUM_RANKS; r++) begin
        if (cand == 4'(r + 1)) counts[r] <= counts[r] - 3'd1;
      end
      o_CardsLeft <= o_CardsLeft - 6'd1;
    end
  end

  always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
    if (i_ResetNeg) begin
      o_Card      <= 4'd0;
      o_CardValue <= 4'd0;
    end else if (accept) begin
      o_Card      <= cand;
      o_CardValue <= card_value(cand);
    end
  end

endmodule
